// File: rtl/nand_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : nand_op_scheduler
//  Description : Drives one shared, external, combinational WIDTH-bit NAND
//                through a fixed multi-pass schedule, one pass per clock, to
//                evaluate NAND, NOT, AND, OR, NOR, XOR or XNOR between a
//                start/done requester and the NAND instance.
//                Optional macro NAND_PASS_CNT_EN adds a saturating 16-bit
//                count of captured NAND passes on output pass_cnt.
//  Revision    : 1.0  initial release
// ============================================================================
module nand_op_scheduler #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] nand_x,
  output logic [WIDTH-1:0] nand_y,
  input  logic [WIDTH-1:0] nand_z
`ifdef NAND_PASS_CNT_EN
  ,
  output logic [15:0]      pass_cnt
`endif
);

  localparam logic [2:0] c_OP_NAND = 3'd0;
  localparam logic [2:0] c_OP_NOT  = 3'd1;
  localparam logic [2:0] c_OP_AND  = 3'd2;
  localparam logic [2:0] c_OP_OR   = 3'd3;
  localparam logic [2:0] c_OP_NOR  = 3'd4;
  localparam logic [2:0] c_OP_XOR  = 3'd5;
  localparam logic [2:0] c_OP_XNOR = 3'd6;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;
  typedef enum logic [1:0] {D_T1 = 2'd0, D_T2 = 2'd1, D_T3 = 2'd2, D_Y = 2'd3} dest_t;

  state_t           state_q, state_d;
  logic [2:0]       pass_q, pass_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] t1_q, t2_q, t3_q;
  logic [WIDTH-1:0] y_q;
  logic             done_q, err_q;

  logic [WIDTH-1:0] w_x, w_y;
  dest_t            w_dest;
  logic             w_last;
  logic             w_reserved;
  logic             w_accept;
  logic             w_capture;

  assign busy      = (state_q == S_EXEC);
  assign done      = done_q;
  assign err       = err_q;
  assign y         = y_q;
  assign w_accept  = (state_q == S_IDLE) && start;
  assign w_capture = busy && !w_reserved;

  // Shared NAND is held at zero whenever no operation is running.
  assign nand_x = busy ? w_x : '0;
  assign nand_y = busy ? w_y : '0;

  // Pass schedule: NAND operands, destination of the result, and last-pass flag.
  always_comb begin
    w_x        = '0;
    w_y        = '0;
    w_dest     = D_Y;
    w_last     = 1'b0;
    w_reserved = 1'b0;
    case (op_q)
      c_OP_NAND: begin
        w_x = a_q; w_y = b_q; w_last = 1'b1;
      end
      c_OP_NOT: begin
        w_x = a_q; w_y = a_q; w_last = 1'b1;
      end
      c_OP_AND: begin
        if (pass_q == 3'd1) begin
          w_x = a_q; w_y = b_q; w_dest = D_T1;
        end else begin
          w_x = t1_q; w_y = t1_q; w_last = 1'b1;
        end
      end
      c_OP_OR, c_OP_NOR: begin
        case (pass_q)
          3'd1: begin w_x = a_q; w_y = a_q; w_dest = D_T1; end
          3'd2: begin w_x = b_q; w_y = b_q; w_dest = D_T2; end
          3'd3: begin
            w_x = t1_q; w_y = t2_q;
            // OR finishes here; NOR keeps the OR result for one inversion.
            if (op_q == c_OP_OR) w_last = 1'b1;
            else                 w_dest = D_T3;
          end
          default: begin w_x = t3_q; w_y = t3_q; w_last = 1'b1; end
        endcase
      end
      c_OP_XOR, c_OP_XNOR: begin
        case (pass_q)
          3'd1: begin w_x = a_q; w_y = b_q;  w_dest = D_T1; end
          3'd2: begin w_x = a_q; w_y = t1_q; w_dest = D_T2; end
          3'd3: begin w_x = b_q; w_y = t1_q; w_dest = D_T3; end
          3'd4: begin
            w_x = t2_q; w_y = t3_q;
            // XNOR parks the XOR result in t1 and inverts it on pass 5.
            if (op_q == c_OP_XOR) w_last = 1'b1;
            else                  w_dest = D_T1;
          end
          default: begin w_x = t1_q; w_y = t1_q; w_last = 1'b1; end
        endcase
      end
      default: begin
        // Reserved op: no NAND pass, finishes on the first edge with err.
        w_reserved = 1'b1;
        w_last     = 1'b1;
      end
    endcase
  end

  // FSM state and pass-index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pass_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
    end
  end

  // FSM next state: accept from idle, step passes, return to idle on the last one.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EXEC;
          pass_d  = 3'd1;
        end
      end
      default: begin
        if (w_last) begin
          state_d = S_IDLE;
          pass_d  = 3'd0;
        end else begin
          pass_d  = pass_q + 3'd1;
        end
      end
    endcase
  end

  // Datapath: latch request on accept, capture nand_z each pass, flag completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 3'd0;
      a_q    <= '0;
      b_q    <= '0;
      t1_q   <= '0;
      t2_q   <= '0;
      t3_q   <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (w_accept) begin
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
        err_q <= 1'b0;
      end
      if (busy) begin
        if (w_reserved) begin
          y_q    <= '0;
          err_q  <= 1'b1;
          done_q <= 1'b1;
        end else begin
          case (w_dest)
            D_T1:    t1_q <= nand_z;
            D_T2:    t2_q <= nand_z;
            D_T3:    t3_q <= nand_z;
            default: y_q  <= nand_z;
          endcase
          if (w_last) done_q <= 1'b1;
        end
      end
    end
  end

`ifdef NAND_PASS_CNT_EN
  logic [15:0] pass_cnt_q;

  // Saturating count of edges that captured a NAND pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= 16'd0;
    end else if (w_capture && (pass_cnt_q != 16'hFFFF)) begin
      pass_cnt_q <= pass_cnt_q + 16'd1;
    end
  end

  assign pass_cnt = pass_cnt_q;
`else
  logic w_capture_unused;
  assign w_capture_unused = w_capture;
`endif

endmodule
`default_nettype wire
